vm_txn_ctrl: RTL

VM_TXN_CTRL -- requirements
Module: vm_txn_ctrl

---
 rtl/vm_txn_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vm_txn_ctrl.sv
// Vending machine transaction controller: coin credit, stock tracking,
// item dispense and change return over valid/ready handshakes.
module vm_txn_ctrl #(
    parameter int NUM_ITEMS = 7,
    parameter int MAX_COUNT = 8,
    parameter int MAX_BAL   = 200,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic [2:0] select,
    input  logic       cancel,
    input  logic       restock,
    output logic       dispense_valid,
    output logic [2:0] dispense_item,
    input  logic       dispense_ready,
    output logic       change_valid,
    output logic [7:0] change_amount,
    input  logic       change_ready,
    output logic [1:0] status,
    output logic [7:0] balance,
    output logic       coin_reject
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] NO_STATUS    = 2'd0;
    localparam logic [1:0] AVAILABLE    = 2'd1;
    localparam logic [1:0] OUT_OF_STOCK = 2'd2;
    localparam logic [1:0] ERROR        = 2'd3;

    typedef enum logic [2:0] {
        IDLE, COLLECT, CHECK, DISPENSE, REFUND, RESTOCK
    } state_t;

    state_t state, state_next;

    logic [3:0]    count [NUM_ITEMS];
    logic [2:0]    sel;
    logic [2:0]    idx;
    logic [TW-1:0] tmr;
    logic [2:0]    coin_val;
    logic [8:0]    bal_sum;
    logic [7:0]    bal_in;
    logic          coin_open;
    logic          coin_take;
    logic [3:0]    cur_count;
    logic [7:0]    cur_cost;
    logic          in_stock;
    logic          afford;
    logic          tmo_hit;

    function automatic logic [7:0] cost_of(input logic [2:0] s);
        logic [7:0] c;
        case (s)
            3'd1:    c = 8'd10;
            3'd2:    c = 8'd20;
            3'd3:    c = 8'd20;
            3'd4:    c = 8'd20;
            3'd5:    c = 8'd40;
            3'd6:    c = 8'd25;
            3'd7:    c = 8'd30;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    always_comb begin
        case (coin)
            2'd1:    coin_val = 3'd1;
            2'd2:    coin_val = 3'd2;
            2'd3:    coin_val = 3'd5;
            default: coin_val = 3'd0;
        endcase
    end

    assign bal_sum   = {1'b0, balance} + {6'b0, coin_val};
    assign coin_open = (state == IDLE && !restock) || state == COLLECT;
    assign coin_take = coin != 2'd0 && coin_open
                       && bal_sum <= 9'(MAX_BAL);
    assign bal_in    = coin_take ? bal_sum[7:0] : balance;

    assign idx       = sel - 3'd1;
    assign cur_count = (int'(idx) < NUM_ITEMS) ? count[idx] : 4'd0;
    assign cur_cost  = cost_of(sel);
    assign in_stock  = cur_count != 4'd0;
    assign afford    = balance >= cur_cost;
    assign tmo_hit   = !coin_take && tmr == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (restock)        state_next = RESTOCK;
                else if (coin_take) state_next = COLLECT;
            end
            RESTOCK: state_next = IDLE;
            COLLECT: begin
                if (cancel)               state_next = REFUND;
                else if (select != 3'd0)  state_next = CHECK;
                else if (tmo_hit)         state_next = REFUND;
            end
            CHECK: begin
                if (!in_stock || !afford) state_next = COLLECT;
                else                      state_next = DISPENSE;
            end
            DISPENSE: begin
                if (dispense_ready)
                    state_next = (balance != 8'd0) ? REFUND : IDLE;
            end
            REFUND: begin
                if (change_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            balance        <= 8'd0;
            tmr            <= '0;
            sel            <= 3'd0;
            status         <= NO_STATUS;
            dispense_valid <= 1'b0;
            dispense_item  <= 3'd0;
            change_valid   <= 1'b0;
            change_amount  <= 8'd0;
            coin_reject    <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++)
                count[i] <= 4'(MAX_COUNT);
        end else begin
            coin_reject <= coin != 2'd0 && !coin_take;
            if (coin_take)
                balance <= bal_sum[7:0];

            // Timer restarts on entry to COLLECT and on every accepted coin.
            if (coin_take || (state != COLLECT && state_next == COLLECT))
                tmr <= '0;
            else if (state == COLLECT)
                tmr <= tmr + TW'(1);

            case (state)
                COLLECT: begin
                    if (!cancel && select != 3'd0)
                        sel <= select;
                    if (state_next == REFUND) begin
                        change_valid  <= 1'b1;
                        change_amount <= bal_in;
                    end
                end
                CHECK: begin
                    if (!in_stock) begin
                        status <= OUT_OF_STOCK;
                    end else if (!afford) begin
                        status <= ERROR;
                    end else begin
                        status         <= AVAILABLE;
                        count[idx]     <= cur_count - 4'd1;
                        balance        <= balance - cur_cost;
                        dispense_valid <= 1'b1;
                        dispense_item  <= sel;
                    end
                end
                DISPENSE: begin
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        if (balance != 8'd0) begin
                            change_valid  <= 1'b1;
                            change_amount <= balance;
                        end
                    end
                end
                REFUND: begin
                    if (change_ready) begin
                        change_valid  <= 1'b0;
                        change_amount <= 8'd0;
                        balance       <= 8'd0;
                    end
                end
                RESTOCK: begin
                    for (int i = 0; i < NUM_ITEMS; i++)
                        count[i] <= 4'(MAX_COUNT);
                end
                default: ;
            endcase

            if (state_next == IDLE)
                status <= NO_STATUS;
        end
    end

endmodule
